gray2bin_seq: RTL and testbench

GRAY2BIN_SEQ -- requirements
Module: gray2bin_seq

---
 rtl/gray2bin_seq.sv | 157 +++++++++++++++
 tb/tb_gray2bin_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray2bin_seq.sv
// -----------------------------------------------------------------------------
// gray2bin_seq
//
// Bit-serial Gray-to-binary decoder with ready/valid handshakes on both sides
// and an adjacency checker that flags any accepted word that is not exactly
// one bit away from the previously accepted word.
//
// A word accepted in IDLE is decoded MSB first, one bit per clock, over WIDTH
// DECODE cycles. The result is then held in DONE until the consumer takes it.
// Only one word is in flight at a time, so the minimum period per word is
// WIDTH+2 cycles.
//
// Parameters
//   WIDTH      Gray/binary word width (2..32)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   in_gray carries a word to accept
//   in_ready   block is idle and will accept a word (high in IDLE only)
//   in_gray    Gray-coded input word
//   out_valid  out_bin/adj_err carry a finished result (high in DONE only)
//   out_ready  consumer takes the result
//   out_bin    decoded binary word (partially resolved while decoding)
//   adj_err    accepted word was not at Hamming distance 1 from the previous one
// -----------------------------------------------------------------------------
module gray2bin_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             adj_err
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic [WIDTH-1:0] bin_reg, bin_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0] prev_gray_reg, prev_gray_next;
  logic             have_prev_reg, have_prev_next;
  logic             adj_err_reg, adj_err_next;

  // bin_reg with the bit selected by idx_reg replaced by its resolved value.
  logic [WIDTH-1:0] bin_resolved;

  // Adjacency: the XOR of consecutive words must have exactly one bit set.
  logic [WIDTH-1:0] diff;
  logic             one_bit_diff;

  assign diff         = in_gray ^ prev_gray_reg;
  assign one_bit_diff = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

  // One resolver per bit position; only the position matching idx_reg changes.
  // The MSB copies the Gray bit; every lower bit folds in the binary bit above,
  // which was resolved on the previous DECODE cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_resolve
      logic bit_val;
      if (gi == WIDTH - 1) begin : g_msb
        assign bit_val = gray_reg[gi];
      end else begin : g_lower
        assign bit_val = bin_reg[gi+1] ^ gray_reg[gi];
      end
      assign bin_resolved[gi] = (idx_reg == IDX_W'(gi)) ? bit_val : bin_reg[gi];
    end
  endgenerate

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      gray_reg      <= '0;
      bin_reg       <= '0;
      idx_reg       <= IDX_MSB;
      prev_gray_reg <= '0;
      have_prev_reg <= 1'b0;
      adj_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gray_reg      <= gray_next;
      bin_reg       <= bin_next;
      idx_reg       <= idx_next;
      prev_gray_reg <= prev_gray_next;
      have_prev_reg <= have_prev_next;
      adj_err_reg   <= adj_err_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next     = state_reg;
    gray_next      = gray_reg;
    bin_next       = bin_reg;
    idx_next       = idx_reg;
    prev_gray_next = prev_gray_reg;
    have_prev_next = have_prev_reg;
    adj_err_next   = adj_err_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next     = DECODE;
          gray_next      = in_gray;
          // Start from zero so the partial word only shows resolved bits.
          bin_next       = '0;
          idx_next       = IDX_MSB;
          adj_err_next   = have_prev_reg && !one_bit_diff;
          prev_gray_next = in_gray;
          have_prev_next = 1'b1;
        end
      end

      DECODE: begin
        bin_next = bin_resolved;
        if (idx_reg == '0) begin
          state_next = DONE;
          idx_next   = IDX_MSB;
        end else begin
          idx_next = idx_reg - IDX_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake flags come straight from the state; data outputs are registers.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_bin   = bin_reg;
  assign adj_err   = adj_err_reg;

endmodule

// File: tb/tb_gray2bin_seq.sv
// -----------------------------------------------------------------------------
// tb_gray2bin_seq
//
// Directed bench for gray2bin_seq at WIDTH=8. Each scenario task drives its own
// stimulus and compares DUT outputs against hand-computed values. Outputs are
// sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gray2bin_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_gray;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bin;
  logic         adj_err;

  int tests_run;
  int tests_failed;

  gray2bin_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .adj_err   (adj_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Drives one word through the block with out_ready already high. Returns the
  // number of edges from the input handshake to out_valid, the result seen, the
  // in_ready level while out_valid was high, and a timeout flag.
  task automatic send_word(input logic [W-1:0] g, output int lat,
                           output logic [W-1:0] bin, output logic aerr,
                           output logic ir_done, output bit to);
    in_valid = 1'b1;
    in_gray  = g;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    to  = 1'b1;
    bin = '0;
    aerr = 1'b0;
    ir_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!to) begin
      bin     = out_bin;
      aerr    = adj_err;
      ir_done = in_ready;
      @(posedge clk); #1;
    end
    $display("[TB] word gray=%02h bin=%02h adj=%0b lat=%0d timeout=%0b", g, bin, aerr, lat, to);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reset asserted in DONE mid-cycle must clear the outputs without a clock edge.
  task automatic test_reset();
    bit to;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_gray   = 8'hC0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (to || out_bin !== 8'h80) begin
      tests_failed++;
      $display("FAIL reset_predone: out_valid=%0b out_bin=%02h required out_valid=1 out_bin=80", out_valid, out_bin);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %0b required 0", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    tests_run++;
    if (out_bin !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_out_bin: got %02h required 00", out_bin);
    end
    tests_run++;
    if (adj_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_adj_err: got %0b required 0", adj_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    $display("[TB] reset in DONE done");
  endtask

  // First word after reset; handshake must land on the first edge after release.
  task automatic test_single_word();
    int lat;
    logic [W-1:0] bin;
    logic aerr, ir;
    bit to;
    send_word(8'hC0, lat, bin, aerr, ir, to);
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL single_timeout: no out_valid");
    end else begin
      tests_run += 4;
      if (lat !== 8) begin
        tests_failed++;
        $display("FAIL single_latency: got %0d required 8", lat);
      end
      if (bin !== 8'h80) begin
        tests_failed++;
        $display("FAIL single_bin: got %02h required 80", bin);
      end
      if (aerr !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_adj: got %0b required 0", aerr);
      end
      if (ir !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_ready_in_done: in_ready got %0b required 0", ir);
      end
    end
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_after: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_adjacency();
    logic [W-1:0] g_tab [5] = '{8'h00, 8'h01, 8'h03, 8'h00, 8'h00};
    logic [W-1:0] b_tab [5] = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h00};
    logic         a_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    logic [W-1:0] bin;
    logic aerr, ir;
    bit to;
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      send_word(g_tab[k], lat, bin, aerr, ir, to);
      tests_run++;
      if (to) begin
        tests_failed++;
        $display("FAIL adj_timeout[%0d]: no out_valid", k);
      end else begin
        tests_run += 2;
        if (bin !== b_tab[k]) begin
          tests_failed++;
          $display("FAIL adj_bin[%0d]: got %02h required %02h", k, bin, b_tab[k]);
        end
        if (aerr !== a_tab[k]) begin
          tests_failed++;
          $display("FAIL adj_err[%0d]: got %0b required %0b", k, aerr, a_tab[k]);
        end
      end
    end
  endtask

  // Previous accepted word is 0x00. 0x07 is three bits away -> adj_err=1,
  // binary 0x05. Input activity in DONE must not be captured.
  task automatic test_backpressure();
    int lat;
    logic [W-1:0] bin;
    logic aerr, ir;
    bit to;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_gray   = 8'h07;
    @(posedge clk); #1;
    in_valid = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL bp_timeout: no out_valid");
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      in_gray  = k[0] ? 8'h55 : 8'hAA;
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_bin !== 8'h05 || adj_err !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: out_valid=%0b out_bin=%02h adj_err=%0b in_ready=%0b required 1 05 1 0",
                 k, out_valid, out_bin, adj_err, in_ready);
      end
    end
    $display("[TB] backpressure hold bin=%02h adj=%0b", out_bin, adj_err);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    // 0x06 is one bit from 0x07; a stray capture of 0xAA/0x55 would flag it.
    send_word(8'h06, lat, bin, aerr, ir, to);
    tests_run++;
    if (to || lat !== 8 || bin !== 8'h04 || aerr !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_next: lat=%0d bin=%02h adj=%0b timeout=%0b required 8 04 0 0", lat, bin, aerr, to);
    end
  endtask

  task automatic test_reset_mid_decode();
    int lat;
    logic [W-1:0] bin;
    logic aerr, ir;
    bit to;
    in_valid = 1'b1;
    in_gray  = 8'h3C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // idx is 7 after the handshake edge; four DECODE edges bring it to 3.
    repeat (4) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_decoding: in_ready=%0b out_valid=%0b required 0 0", in_ready, out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bin !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset: out_valid=%0b in_ready=%0b out_bin=%02h required 0 1 00", out_valid, in_ready, out_bin);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_word(8'h80, lat, bin, aerr, ir, to);
    tests_run++;
    if (to || lat !== 8 || bin !== 8'hFF || aerr !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_next: lat=%0d bin=%02h adj=%0b timeout=%0b required 8 FF 0 0", lat, bin, aerr, to);
    end
  endtask

  // Counting sequence through every code, then wrap back to Gray(0).
  // Previous accepted word is 0x80 = Gray(255), so Gray(0) is adjacent.
  task automatic test_exhaustive();
    int lat;
    logic [W-1:0] bin;
    logic aerr, ir;
    logic [W-1:0] x;
    logic [W-1:0] g;
    bit to;
    for (int n = 0; n <= 256; n++) begin
      x = W'(n % 256);
      g = x ^ (x >> 1);
      send_word(g, lat, bin, aerr, ir, to);
      tests_run++;
      if (to) begin
        tests_failed++;
        $display("FAIL exh_timeout[%0d]: no out_valid", n);
      end else begin
        tests_run += 3;
        if (bin !== x) begin
          tests_failed++;
          $display("FAIL exh_bin[%0d]: got %02h required %02h", n, bin, x);
        end
        if (aerr !== 1'b0) begin
          tests_failed++;
          $display("FAIL exh_adj[%0d]: got %0b required 0", n, aerr);
        end
        if (lat !== 8) begin
          tests_failed++;
          $display("FAIL exh_lat[%0d]: got %0d required 8", n, lat);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_gray   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    test_reset();
    test_single_word();
    test_adjacency();
    test_backpressure();
    test_reset_mid_decode();
    test_exhaustive();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
